spram_arbiter: RTL and testbench
================================

# spram_arbiter

Two-requester round-robin arbiter and sequencer in front of the single-port RAM (`SPRAM`). Each requester issues independent read/write requests over a valid/ready handshake. The block grants at most one request per cycle to the RAM port and routes each registered read result back to the requester that issued it. It sits between the datapath clients and one `SPRAM` instance, whose read latency is one cycle.

## Interface
- `DATA_WIDTH`, 16, RAM word width
- `ADDR_WIDTH`, 8, RAM address width
- `clk`  in  1  single clock; all state updates on rising edge
- `reset`  in  1  asynchronous, active-low reset (asserted when 0)
- `a_req_valid`, `b_req_valid`  in  1  request present
- `a_req_ready`, `b_req_ready`  out  1  request accepted this cycle
- `a_req_we`, `b_req_we`  in  1  1 = write, 0 = read
- `a_req_addr`, `b_req_addr`  in  ADDR_WIDTH  target address
- `a_req_wdata`, `b_req_wdata`  in  DATA_WIDTH  write data
- `a_rsp_valid`, `b_rsp_valid`  out  1  read data valid, one-cycle pulse
- `a_rsp_rdata`, `b_rsp_rdata`  out  DATA_WIDTH  read data
- `ram_addr`  out  ADDR_WIDTH  to RAM `addr`
- `ram_wdata`  out  DATA_WIDTH  to RAM `write_data`
- `ram_we`, `ram_re`  out  1  to RAM `write_en` / `read_en`
- `ram_rdata`  in  DATA_WIDTH  from RAM `read_data`

## Operation
- **Handshake.** A request transfers on a rising edge where `x_req_valid && x_req_ready`. Once asserted, `valid` and the payload are held stable until accepted. `ready` may depend combinationally on `valid`. `valid` must not depend on `ready`.
- **Arbitration.**
  - Only one requester valid: it is granted.
  - Both valid: the requester not granted most recently wins.
  - `last_grant` flop updates only on an accepted transfer. Reset value is B, so A wins the first contention.
- **RAM drive.** The RAM port is driven combinationally from the granted payload.
  - Granted write: `ram_we = 1`, `ram_re = 0`.
  - Granted read: `ram_re = 1`, `ram_we = 0`.
  - No grant: both 0; `ram_addr` and `ram_wdata` are don't-care.
- **Read return.**
  - On an accepted read, the `pend_a` or `pend_b` flop is set for exactly one cycle.
  - `x_rsp_valid = pend_x`.
  - `x_rsp_rdata = ram_rdata` while `pend_x`; otherwise 0.
- **Writes.** No response is produced.
- **Back-to-back.** One transfer per cycle sustained. With both requesters continuously valid, grants alternate A, B, A, B.
- **Ordering.**
  - Across requesters, accesses reach the RAM in grant order.
  - A write granted in cycle N followed by a read of the same address granted in cycle N+1 returns the new data.
- **Reset.** Asserting `reset` mid-operation clears `pend_a`, `pend_b` and `last_grant` immediately, and any in-flight read response is dropped. Requesters re-issue after reset.

## Timing
- **Reset values.**
  - `a_rsp_valid = b_rsp_valid = 0`; `a_rsp_rdata = b_rsp_rdata = 0`.
  - `ram_we = ram_re = 0` and `a_req_ready = b_req_ready = 0`, provided no `req_valid` is asserted while in reset.
  - While in reset, grants are suppressed: both `ready` outputs are forced to 0.
- **Read latency.** Accept at edge N, `rsp_valid` high during the cycle after edge N, i.e. 1 cycle.
- **Write latency.** Data is written to the RAM at the accepting edge.
- **Fairness.** Worst-case wait for a continuously-valid requester is 1 cycle.
- **Combinational paths.** `req_valid` → `req_ready` / `ram_*`, and `ram_rdata` → `rsp_rdata`. No other combinational paths.

## Structure
- **Package `spram_arb_pkg`.**
  - `req_id_t` enum `{REQ_A, REQ_B}`.
  - Localparams `DEF_DATA_WIDTH = 16` and `DEF_ADDR_WIDTH = 8`.
- **Sub-module `rr_arb2`.**
  - Inputs: `req[1:0]`, `accept`.
  - Outputs: `grant[1:0]`, one-hot or zero.
  - Owns the `last_grant` flop.
  - The payload mux and pending-response logic stay in `spram_arbiter`.

## Test plan
- **Write then read.** After reset release: A writes 13 to address 12, then A reads address 12 → `a_req_ready` high each cycle; `a_rsp_valid` pulses one cycle after the read with `a_rsp_rdata = 13`; `b_rsp_valid` stays 0.
- **Contention.** A and B both continuously valid reading addresses 1 and 2, preloaded with 0x0011 and 0x0022 → grants A, B, A, B; `a_rsp_rdata = 0x0011` and `b_rsp_rdata = 0x0022` alternate with one-cycle latency.
- **Cross-requester ordering.** A writes 0xBEEF to address 5 in cycle N; B reads address 5 in cycle N+1 → `b_rsp_rdata = 0xBEEF` at cycle N+2.
- **Backpressure hold.** B's request is held while A is granted → B's payload is unchanged and B is accepted the next cycle; no request is lost or duplicated (count = 2 transfers).
- **Reset mid-read.** `reset` is driven low in the cycle after A's read is accepted → `a_rsp_valid` goes low immediately and no response appears after release; the first contention after reset grants A.

Source files
------------

// File: rtl/spram_arb_pkg.sv
// Shared types and default widths for the two-port round-robin SPRAM arbiter.
package spram_arb_pkg;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_ADDR_WIDTH = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant logic; remembers the last accepted requester.
module rr_arb2
  import spram_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  req_id_t r_last_grant;

  // On contention the requester that did not win last time goes first.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = (r_last_grant == REQ_B) ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= REQ_B;
    end else if (accept) begin
      r_last_grant <= grant[1] ? REQ_B : REQ_A;
    end
  end

endmodule

// File: rtl/spram_arbiter.sv
// Arbitrates two valid/ready requesters onto one single-port RAM and steers
// each one-cycle-latency read result back to the requester that issued it.
module spram_arbiter
  import spram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req_valid,
  output logic                  a_req_ready,
  input  logic                  a_req_we,
  input  logic [ADDR_WIDTH-1:0] a_req_addr,
  input  logic [DATA_WIDTH-1:0] a_req_wdata,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_req_we,
  input  logic [ADDR_WIDTH-1:0] b_req_addr,
  input  logic [DATA_WIDTH-1:0] b_req_wdata,
  output logic                  a_rsp_valid,
  output logic [DATA_WIDTH-1:0] a_rsp_rdata,
  output logic                  b_rsp_valid,
  output logic [DATA_WIDTH-1:0] b_rsp_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  output logic                  ram_re,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  logic [1:0] w_req;
  logic [1:0] w_grant;
  logic       w_accept;
  logic       w_sel_we;
  logic       r_pend_a;
  logic       r_pend_b;

  // Requests are masked while reset is held so nothing reaches the RAM.
  assign w_req    = {b_req_valid, a_req_valid} & {2{reset}};
  assign w_accept = |w_grant;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req    (w_req),
    .accept (w_accept),
    .grant  (w_grant)
  );

  assign a_req_ready = w_grant[0];
  assign b_req_ready = w_grant[1];

  always_comb begin
    ram_addr  = a_req_addr;
    ram_wdata = a_req_wdata;
    w_sel_we  = a_req_we;
    if (w_grant[1]) begin
      ram_addr  = b_req_addr;
      ram_wdata = b_req_wdata;
      w_sel_we  = b_req_we;
    end
    ram_we = w_accept & w_sel_we;
    ram_re = w_accept & ~w_sel_we;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_a <= 1'b0;
      r_pend_b <= 1'b0;
    end else begin
      r_pend_a <= w_grant[0] & ~a_req_we;
      r_pend_b <= w_grant[1] & ~b_req_we;
    end
  end

  assign a_rsp_valid = r_pend_a;
  assign b_rsp_valid = r_pend_b;
  assign a_rsp_rdata = r_pend_a ? ram_rdata : '0;
  assign b_rsp_rdata = r_pend_b ? ram_rdata : '0;

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter with a behavioural one-cycle-latency SPRAM.
module tb_spram_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_req_valid, a_req_ready, a_req_we;
  logic [7:0]  a_req_addr;
  logic [15:0] a_req_wdata;
  logic        b_req_valid, b_req_ready, b_req_we;
  logic [7:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic        a_rsp_valid, b_rsp_valid;
  logic [15:0] a_rsp_rdata, b_rsp_rdata;
  logic [7:0]  ram_addr;
  logic [15:0] ram_wdata;
  logic        ram_we, ram_re;
  logic [15:0] ram_rdata;

  logic [15:0] mem [256];
  int          checks = 0;
  int          errors = 0;
  int          xfer_cnt = 0;
  int          xfer_base;

  always #5 clk = ~clk;

  spram_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .a_req_valid (a_req_valid),
    .a_req_ready (a_req_ready),
    .a_req_we    (a_req_we),
    .a_req_addr  (a_req_addr),
    .a_req_wdata (a_req_wdata),
    .b_req_valid (b_req_valid),
    .b_req_ready (b_req_ready),
    .b_req_we    (b_req_we),
    .b_req_addr  (b_req_addr),
    .b_req_wdata (b_req_wdata),
    .a_rsp_valid (a_rsp_valid),
    .a_rsp_rdata (a_rsp_rdata),
    .b_rsp_valid (b_rsp_valid),
    .b_rsp_rdata (b_rsp_rdata),
    .ram_addr    (ram_addr),
    .ram_wdata   (ram_wdata),
    .ram_we      (ram_we),
    .ram_re      (ram_re),
    .ram_rdata   (ram_rdata)
  );

  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    if (ram_re) ram_rdata <= mem[ram_addr];
  end

  always @(posedge clk) begin
    xfer_cnt <= xfer_cnt + int'(a_req_valid && a_req_ready) + int'(b_req_valid && b_req_ready);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end else begin
      $display("ok   %s: 0x%0h", tag, obs);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    a_req_valid = 1'b0;
    b_req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[1] = 16'h0011;
    mem[2] = 16'h0022;
    ram_rdata = 16'h0000;
    reset = 1'b0;
    idle_all();
    a_req_we = 1'b0; a_req_addr = 8'd0; a_req_wdata = 16'd0;
    b_req_we = 1'b0; b_req_addr = 8'd0; b_req_wdata = 16'd0;

    // Reset state, then a request raised during reset must stay blocked.
    repeat (2) step();
    @(negedge clk);
    check("rst a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rst b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    check("rst a_rsp_rdata", 32'(a_rsp_rdata), 32'd0);
    check("rst b_rsp_rdata", 32'(b_rsp_rdata), 32'd0);
    check("rst ram_we_re", {30'd0, ram_we, ram_re}, 32'd0);
    check("rst ready", {30'd0, a_req_ready, b_req_ready}, 32'd0);
    step();
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'd99; a_req_wdata = 16'hDEAD;
    @(negedge clk);
    check("rst gated a_ready", 32'(a_req_ready), 32'd0);
    check("rst gated ram_we", 32'(ram_we), 32'd0);
    step();
    idle_all();
    reset = 1'b1;

    // Write then read from A.
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'd12; a_req_wdata = 16'd13;
    @(negedge clk);
    check("wr a_ready", 32'(a_req_ready), 32'd1);
    check("wr ram_we", {30'd0, ram_we, ram_re}, 32'd2);
    check("wr ram_addr", 32'(ram_addr), 32'd12);
    check("wr ram_wdata", 32'(ram_wdata), 32'd13);
    step();
    a_req_we = 1'b0;
    @(negedge clk);
    check("rd a_ready", 32'(a_req_ready), 32'd1);
    check("rd ram_re", {30'd0, ram_we, ram_re}, 32'd1);
    check("rd no early rsp", 32'(a_rsp_valid), 32'd0);
    step();
    idle_all();
    @(negedge clk);
    check("rd a_rsp_valid", 32'(a_rsp_valid), 32'd1);
    check("rd a_rsp_rdata", 32'(a_rsp_rdata), 32'd13);
    check("rd b_rsp_valid", 32'(b_rsp_valid), 32'd0);
    step();
    @(negedge clk);
    check("rd rsp pulse end", 32'(a_rsp_valid), 32'd0);

    // Cross-requester ordering: A writes, B reads same address next cycle.
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'd5; a_req_wdata = 16'hBEEF;
    @(negedge clk);
    check("xo a_ready", 32'(a_req_ready), 32'd1);
    step();
    idle_all();
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'd5;
    @(negedge clk);
    check("xo b_ready", 32'(b_req_ready), 32'd1);
    check("xo ram_addr", 32'(ram_addr), 32'd5);
    step();
    idle_all();
    @(negedge clk);
    check("xo b_rsp_valid", 32'(b_rsp_valid), 32'd1);
    check("xo b_rsp_rdata", 32'(b_rsp_rdata), 32'hBEEF);
    check("xo a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    step();

    // Contention: last grant was B, so A, B, A, B.
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'd1;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'd2;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("ct%0d a_ready", k), 32'(a_req_ready), 32'((k % 2) == 0));
      check($sformatf("ct%0d b_ready", k), 32'(b_req_ready), 32'((k % 2) == 1));
      if (k > 0) begin
        check($sformatf("ct%0d a_rsp_valid", k), 32'(a_rsp_valid), 32'((k % 2) == 1));
        check($sformatf("ct%0d b_rsp_valid", k), 32'(b_rsp_valid), 32'((k % 2) == 0));
        check($sformatf("ct%0d rdata", k), 32'(a_rsp_rdata | b_rsp_rdata),
              ((k % 2) == 1) ? 32'h0011 : 32'h0022);
      end
      step();
    end
    idle_all();
    @(negedge clk);
    check("ct end b_rsp_rdata", 32'(b_rsp_rdata), 32'h0022);
    check("ct end a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    step();

    // Backpressure: B held while A wins, then B accepted; exactly 2 transfers.
    xfer_base = xfer_cnt;
    a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'd7; a_req_wdata = 16'h0707;
    b_req_valid = 1'b1; b_req_we = 1'b1; b_req_addr = 8'd8; b_req_wdata = 16'h0808;
    @(negedge clk);
    check("bp a_ready", 32'(a_req_ready), 32'd1);
    check("bp b_held", 32'(b_req_ready), 32'd0);
    step();
    a_req_valid = 1'b0;
    @(negedge clk);
    check("bp b_ready", 32'(b_req_ready), 32'd1);
    check("bp ram_wdata", 32'(ram_wdata), 32'h0808);
    step();
    idle_all();
    step();
    check("bp xfer count", 32'(xfer_cnt - xfer_base), 32'd2);
    check("bp mem7", 32'(mem[7]), 32'h0707);
    check("bp mem8", 32'(mem[8]), 32'h0808);

    // Reset in the cycle after A's read is accepted.
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'd12;
    @(negedge clk);
    check("rr a_ready", 32'(a_req_ready), 32'd1);
    step();
    idle_all();
    reset = 1'b0;
    @(negedge clk);
    check("rr a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    check("rr a_rsp_rdata", 32'(a_rsp_rdata), 32'd0);
    step();
    reset = 1'b1;
    @(negedge clk);
    check("rr post a_rsp_valid", 32'(a_rsp_valid), 32'd0);
    a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 8'd1;
    b_req_valid = 1'b1; b_req_we = 1'b0; b_req_addr = 8'd2;
    #1;
    check("rr first a_ready", 32'(a_req_ready), 32'd1);
    check("rr first b_ready", 32'(b_req_ready), 32'd0);
    step();
    @(negedge clk);
    check("rr second b_ready", 32'(b_req_ready), 32'd1);
    check("rr a_rsp_rdata", 32'(a_rsp_rdata), 32'h0011);
    step();
    idle_all();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
